// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares the single BRAM/SPRAM access port between the host requester (H,
//   UART command controller) and the compute requester (C, adder / NN core).
//   Fixed host priority, with a starvation guard that forces C to win after
//   MAX_WAIT denied IDLE cycles. Read data is returned to the issuing port.
//
// Handshake (both ports): a requester holds xx_req high with stable command
//   fields. Requests are only sampled in IDLE. xx_gnt pulses for one cycle
//   in the cycle the command is on the memory bus. By the cycle after gnt the
//   requester must drop req or present its next command. For reads,
//   xx_rvalid pulses once, RD_LAT cycles after gnt, with xx_rdata valid;
//   xx_rdata then holds until that port's next read returns.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   h_* / c_*                  requester command inputs, gnt/rvalid/rdata out
//   mem_*                      shared memory port (mem_data_out is read data)
//   busy                       FSM not in IDLE
//   perf_h_grants, perf_c_grants, perf_c_stall
//                              16-bit saturating counters, live only when
//                              MEM_ARB_PERF_EN is defined, else tied to 0
//   dbg_state, dbg_starve_cnt  FSM state and starvation counter for debug
//
// Optional feature macro: MEM_ARB_PERF_EN

module mem_arbiter #(
  parameter int MEM_SELECT_BITS = 4,
  parameter int ADDR_BITS       = 14,
  parameter int DATA_BITS       = 16,
  parameter int RD_LAT          = 1,
  parameter int MAX_WAIT        = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       h_req,
  input  logic                       h_we,
  input  logic                       h_bram_or_spram,
  input  logic [MEM_SELECT_BITS-1:0] h_sel,
  input  logic [ADDR_BITS-1:0]       h_addr,
  input  logic [DATA_BITS-1:0]       h_wdata,
  output logic                       h_gnt,
  output logic                       h_rvalid,
  output logic [DATA_BITS-1:0]       h_rdata,
  input  logic                       c_req,
  input  logic                       c_we,
  input  logic                       c_bram_or_spram,
  input  logic [MEM_SELECT_BITS-1:0] c_sel,
  input  logic [ADDR_BITS-1:0]       c_addr,
  input  logic [DATA_BITS-1:0]       c_wdata,
  output logic                       c_gnt,
  output logic                       c_rvalid,
  output logic [DATA_BITS-1:0]       c_rdata,
  output logic [MEM_SELECT_BITS-1:0] mem_select,
  output logic [ADDR_BITS-1:0]       mem_addr,
  output logic [DATA_BITS-1:0]       mem_data_in,
  output logic                       mem_rd_en,
  output logic                       mem_wr_en,
  output logic                       mem_bram_or_spram,
  input  logic [DATA_BITS-1:0]       mem_data_out,
  output logic                       busy,
  output logic [15:0]                perf_h_grants,
  output logic [15:0]                perf_c_grants,
  output logic [15:0]                perf_c_stall,
  output logic [1:0]                 dbg_state,
  output logic [15:0]                dbg_starve_cnt
);

  localparam int SW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RWAIT = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic                       owner_c_q, owner_c_d;   // 1 = C owns the access
  logic [MEM_SELECT_BITS-1:0] mem_select_q, mem_select_d;
  logic [ADDR_BITS-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_BITS-1:0]       mem_data_in_q, mem_data_in_d;
  logic                       mem_rd_en_q, mem_rd_en_d;
  logic                       mem_wr_en_q, mem_wr_en_d;
  logic                       mem_bos_q, mem_bos_d;
  logic                       h_gnt_q, h_gnt_d, c_gnt_q, c_gnt_d;
  logic                       h_rvalid_q, h_rvalid_d, c_rvalid_q, c_rvalid_d;
  logic [DATA_BITS-1:0]       h_rdata_q, h_rdata_d, c_rdata_q, c_rdata_d;
  logic [SW-1:0]              starve_q, starve_d;
  logic [2:0]                 lat_q, lat_d;           // cycles since mem_rd_en
  logic                       c_wins;

  always_comb begin
    c_wins        = c_req && (!h_req || (starve_q >= SW'(MAX_WAIT)));
    state_d       = state_q;
    owner_c_d     = owner_c_q;
    mem_select_d  = mem_select_q;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    mem_bos_d     = mem_bos_q;
    mem_rd_en_d   = 1'b0;
    mem_wr_en_d   = 1'b0;
    h_gnt_d       = 1'b0;
    c_gnt_d       = 1'b0;
    h_rvalid_d    = 1'b0;
    c_rvalid_d    = 1'b0;
    starve_d      = starve_q;
    lat_d         = lat_q;
    // The rvalid cycle is the cycle memory data is valid; latch it so the
    // port keeps presenting it afterwards.
    h_rdata_d     = h_rvalid_q ? mem_data_out : h_rdata_q;
    c_rdata_d     = c_rvalid_q ? mem_data_out : c_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (h_req || c_req) begin
          state_d   = S_ISSUE;
          owner_c_d = c_wins;
          if (c_wins) begin
            mem_select_d  = c_sel;
            mem_addr_d    = c_addr;
            mem_data_in_d = c_wdata;
            mem_bos_d     = c_bram_or_spram;
            mem_rd_en_d   = !c_we;
            mem_wr_en_d   = c_we;
            c_gnt_d       = 1'b1;
            starve_d      = '0;
          end else begin
            mem_select_d  = h_sel;
            mem_addr_d    = h_addr;
            mem_data_in_d = h_wdata;
            mem_bos_d     = h_bram_or_spram;
            mem_rd_en_d   = !h_we;
            mem_wr_en_d   = h_we;
            h_gnt_d       = 1'b1;
            if (c_req && (starve_q < SW'(MAX_WAIT))) starve_d = starve_q + 1'b1;
          end
        end
      end
      S_ISSUE: begin
        if (mem_wr_en_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RWAIT;
          lat_d   = 3'd1;
          if (RD_LAT == 1) begin
            h_rvalid_d = !owner_c_q;
            c_rvalid_d = owner_c_q;
          end
        end
      end
      S_RWAIT: begin
        if (h_rvalid_q || c_rvalid_q) begin
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q + 3'd1;
          if ((lat_q + 3'd1) == 3'(RD_LAT)) begin
            h_rvalid_d = !owner_c_q;
            c_rvalid_d = owner_c_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      owner_c_q     <= 1'b0;
      mem_select_q  <= '0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      mem_rd_en_q   <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_bos_q     <= 1'b0;
      h_gnt_q       <= 1'b0;
      c_gnt_q       <= 1'b0;
      h_rvalid_q    <= 1'b0;
      c_rvalid_q    <= 1'b0;
      h_rdata_q     <= '0;
      c_rdata_q     <= '0;
      starve_q      <= '0;
      lat_q         <= '0;
    end else begin
      state_q       <= state_d;
      owner_c_q     <= owner_c_d;
      mem_select_q  <= mem_select_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_bos_q     <= mem_bos_d;
      h_gnt_q       <= h_gnt_d;
      c_gnt_q       <= c_gnt_d;
      h_rvalid_q    <= h_rvalid_d;
      c_rvalid_q    <= c_rvalid_d;
      h_rdata_q     <= h_rdata_d;
      c_rdata_q     <= c_rdata_d;
      starve_q      <= starve_d;
      lat_q         <= lat_d;
    end
  end

  assign h_gnt             = h_gnt_q;
  assign c_gnt             = c_gnt_q;
  assign h_rvalid          = h_rvalid_q;
  assign c_rvalid          = c_rvalid_q;
  assign h_rdata           = h_rvalid_q ? mem_data_out : h_rdata_q;
  assign c_rdata           = c_rvalid_q ? mem_data_out : c_rdata_q;
  assign mem_select        = mem_select_q;
  assign mem_addr          = mem_addr_q;
  assign mem_data_in       = mem_data_in_q;
  assign mem_rd_en         = mem_rd_en_q;
  assign mem_wr_en         = mem_wr_en_q;
  assign mem_bram_or_spram = mem_bos_q;
  assign busy              = (state_q != S_IDLE);
  assign dbg_state         = state_q;
  assign dbg_starve_cnt    = 16'(starve_q);

`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_h_q, perf_h_d, perf_c_q, perf_c_d, perf_s_q, perf_s_d;

  always_comb begin
    perf_h_d = perf_h_q;
    perf_c_d = perf_c_q;
    perf_s_d = perf_s_q;
    if (h_gnt_q && (perf_h_q != 16'hFFFF)) perf_h_d = perf_h_q + 16'd1;
    if (c_gnt_q && (perf_c_q != 16'hFFFF)) perf_c_d = perf_c_q + 16'd1;
    if (c_req && !c_gnt_q && (perf_s_q != 16'hFFFF)) perf_s_d = perf_s_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_h_q <= '0;
      perf_c_q <= '0;
      perf_s_q <= '0;
    end else begin
      perf_h_q <= perf_h_d;
      perf_c_q <= perf_c_d;
      perf_s_q <= perf_s_d;
    end
  end

  assign perf_h_grants = perf_h_q;
  assign perf_c_grants = perf_c_q;
  assign perf_c_stall  = perf_s_q;
`else
  assign perf_h_grants = '0;
  assign perf_c_grants = '0;
  assign perf_c_stall  = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed vectors, expected-event queue,
// negedge monitor that pops and compares on every gnt / rvalid.

module tb_mem_arbiter;

  localparam int EW = 39;

  logic        clk, reset;
  logic        h_req, h_we, h_bos, c_req, c_we, c_bos;
  logic [3:0]  h_sel, c_sel, mem_select;
  logic [13:0] h_addr, c_addr, mem_addr;
  logic [15:0] h_wdata, c_wdata, h_rdata, c_rdata, mem_data_in, mem_data_out;
  logic        h_gnt, h_rvalid, c_gnt, c_rvalid;
  logic        mem_rd_en, mem_wr_en, mem_bos, busy;
  logic [15:0] perf_h_grants, perf_c_grants, perf_c_stall, dbg_starve_cnt;
  logic [1:0]  dbg_state;

  logic [EW-1:0] exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic          started = 1'b0;
  logic [15:0]   mem [256];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .h_req(h_req), .h_we(h_we), .h_bram_or_spram(h_bos), .h_sel(h_sel),
    .h_addr(h_addr), .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
    .h_rdata(h_rdata),
    .c_req(c_req), .c_we(c_we), .c_bram_or_spram(c_bos), .c_sel(c_sel),
    .c_addr(c_addr), .c_wdata(c_wdata), .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .c_rdata(c_rdata),
    .mem_select(mem_select), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_bram_or_spram(mem_bos),
    .mem_data_out(mem_data_out), .busy(busy),
    .perf_h_grants(perf_h_grants), .perf_c_grants(perf_c_grants),
    .perf_c_stall(perf_c_stall), .dbg_state(dbg_state),
    .dbg_starve_cnt(dbg_starve_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Memory model: synchronous read, one cycle latency.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i);
    mem_data_out = 16'h0;
  end

  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr[7:0]] <= mem_data_in;
    if (mem_rd_en) mem_data_out <= mem[mem_addr[7:0]];
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ev_gnt(input logic port, input logic we, input logic bos,
                                           input logic [3:0] sel, input logic [13:0] addr,
                                           input logic [15:0] wd);
    return {2'd1, port, we, bos, sel, addr, (we ? wd : 16'h0)};
  endfunction

  function automatic logic [EW-1:0] ev_rd(input logic port, input logic [15:0] d);
    return {2'd2, port, 1'b0, 1'b0, 4'd0, 14'd0, d};
  endfunction

  task automatic set_cmd(input logic port, input logic we, input logic bos,
                         input logic [3:0] sel, input logic [13:0] addr, input logic [15:0] wd);
    if (port) begin
      c_req = 1'b1; c_we = we; c_bos = bos; c_sel = sel; c_addr = addr; c_wdata = wd;
    end else begin
      h_req = 1'b1; h_we = we; h_bos = bos; h_sel = sel; h_addr = addr; h_wdata = wd;
    end
  endtask

  task automatic wait_gnt(input logic port, output int lat);
    lat = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      if ((port ? c_gnt : h_gnt) === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL gnt_timeout: port %0d got no grant in 32 cycles, required one", port);
    end
  endtask

  task automatic wait_idle();
    int ok;
    ok = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (busy === 1'b0 && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
    end
    chk("idle_within_bound", 64'(ok), 64'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [EW-1:0] act;
    logic [EW-1:0] exp;
    if (started) begin
      if (h_gnt === 1'b1 || c_gnt === 1'b1) begin
        act = {2'd1, c_gnt, mem_wr_en, mem_bos, mem_select, mem_addr,
               (mem_wr_en ? mem_data_in : 16'h0)};
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_gnt: got event 0x%0h, expected none", act);
        end else begin
          exp = exp_q.pop_front();
          chk("gnt_cmd", 64'(act), 64'(exp));
        end
        chk("one_strobe", 64'(mem_wr_en ^ mem_rd_en), 64'd1);
        chk("gnt_exclusive", 64'(h_gnt & c_gnt), 64'd0);
      end else begin
        chk("strobe_outside_issue", 64'({mem_rd_en, mem_wr_en}), 64'd0);
      end
      if (h_rvalid === 1'b1 || c_rvalid === 1'b1) begin
        act = {2'd2, c_rvalid, 1'b0, 1'b0, 4'd0, 14'd0, (c_rvalid ? c_rdata : h_rdata)};
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rvalid: got event 0x%0h, expected none", act);
        end else begin
          exp = exp_q.pop_front();
          chk("rvalid_data", 64'(act), 64'(exp));
        end
        chk("rvalid_exclusive", 64'(h_rvalid & c_rvalid), 64'd0);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int lat, hc, cc;
    reset = 1'b1;
    h_req = 0; h_we = 0; h_bos = 0; h_sel = 0; h_addr = 0; h_wdata = 0;
    c_req = 0; c_we = 0; c_bos = 0; c_sel = 0; c_addr = 0; c_wdata = 0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_handshake", 64'({h_gnt, c_gnt, h_rvalid, c_rvalid, busy}), 64'd0);
    chk("rst_rdata", 64'({h_rdata, c_rdata}), 64'd0);
    chk("rst_mem_bus", 64'({mem_select, mem_addr, mem_data_in, mem_rd_en, mem_wr_en, mem_bos}), 64'd0);
    chk("rst_debug", 64'({dbg_state, dbg_starve_cnt}), 64'd0);
    chk("rst_perf", 64'({perf_h_grants, perf_c_grants, perf_c_stall}), 64'd0);
    reset = 1'b0;
    started = 1'b1;
    @(negedge clk);

    // H write sel=0 addr=0x01 data=0x0005
    exp_q.push_back(ev_gnt(1'b0, 1'b1, 1'b0, 4'd0, 14'h01, 16'h0005));
    set_cmd(1'b0, 1'b1, 1'b0, 4'd0, 14'h01, 16'h0005);
    wait_gnt(1'b0, lat);
    chk("h_wr_gnt_latency", 64'(lat), 64'd1);
    chk("h_wr_busy_issue", 64'(busy), 64'd1);
    h_req = 1'b0;
    @(negedge clk);
    chk("h_wr_busy_n2", 64'(busy), 64'd0);

    // C read addr 0x0A -> 0x000A one cycle after grant
    exp_q.push_back(ev_gnt(1'b1, 1'b0, 1'b0, 4'd1, 14'h0A, 16'h0));
    exp_q.push_back(ev_rd(1'b1, 16'h000A));
    set_cmd(1'b1, 1'b0, 1'b0, 4'd1, 14'h0A, 16'h0);
    wait_gnt(1'b1, lat);
    chk("c_rd_gnt_latency", 64'(lat), 64'd1);
    c_req = 1'b0;
    @(negedge clk);
    chk("c_rd_rvalid_n2", 64'(c_rvalid), 64'd1);
    chk("c_rd_no_h_rvalid", 64'(h_rvalid), 64'd0);
    @(negedge clk);
    chk("c_rd_busy_after", 64'(busy), 64'd0);

    // H read from SPRAM side, sel=3 addr=0x01 -> 0x0005; C rdata must hold
    exp_q.push_back(ev_gnt(1'b0, 1'b0, 1'b1, 4'd3, 14'h01, 16'h0));
    exp_q.push_back(ev_rd(1'b0, 16'h0005));
    set_cmd(1'b0, 1'b0, 1'b1, 4'd3, 14'h01, 16'h0);
    wait_gnt(1'b0, lat);
    h_req = 1'b0;
    @(negedge clk);
    chk("h_rd_rvalid_n2", 64'(h_rvalid), 64'd1);
    chk("c_rdata_holds", 64'(c_rdata), 64'h000A);
    @(negedge clk);
    chk("h_rdata_holds", 64'(h_rdata), 64'h0005);

    // Starvation: both request continuously, 8 H grants then C
    for (int i = 0; i < 8; i++) exp_q.push_back(ev_gnt(1'b0, 1'b1, 1'b0, 4'd1, 14'h30, 16'h1234));
    exp_q.push_back(ev_gnt(1'b1, 1'b1, 1'b0, 4'd2, 14'h20, 16'hC0C0));
    set_cmd(1'b0, 1'b1, 1'b0, 4'd1, 14'h30, 16'h1234);
    set_cmd(1'b1, 1'b1, 1'b0, 4'd2, 14'h20, 16'hC0C0);
    hc = 0;
    cc = 0;
    for (int i = 0; i < 100 && cc == 0; i++) begin
      @(negedge clk);
      if (h_gnt === 1'b1) begin
        hc++;
        if (hc == 8) chk("starve_cnt_at_8", 64'(dbg_starve_cnt), 64'd8);
      end
      if (c_gnt === 1'b1) begin
        cc = 1;
        chk("starve_cnt_cleared", 64'(dbg_starve_cnt), 64'd0);
      end
    end
    h_req = 1'b0;
    c_req = 1'b0;
    chk("starve_h_grants", 64'(hc), 64'd8);
    chk("starve_c_granted", 64'(cc), 64'd1);
    wait_idle();

    // Reset asserted while a read is outstanding: no rvalid may follow
    exp_q.push_back(ev_gnt(1'b1, 1'b0, 1'b0, 4'd0, 14'h0B, 16'h0));
    set_cmd(1'b1, 1'b0, 1'b0, 4'd0, 14'h0B, 16'h0);
    wait_gnt(1'b1, lat);
    reset = 1'b1;
    c_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_rd_state_idle", 64'(dbg_state), 64'd0);
    chk("rst_rd_no_rd_en", 64'(mem_rd_en), 64'd0);
    chk("rst_rd_rdata_cleared", 64'({h_rdata, c_rdata}), 64'd0);

    // Contention: 3 H writes and 2 C reads
    for (int i = 0; i < 3; i++) exp_q.push_back(ev_gnt(1'b0, 1'b1, 1'b0, 4'd4, 14'h40, 16'hAAAA));
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(ev_gnt(1'b1, 1'b0, 1'b0, 4'd5, 14'h0A, 16'h0));
      exp_q.push_back(ev_rd(1'b1, 16'h000A));
    end
    set_cmd(1'b0, 1'b1, 1'b0, 4'd4, 14'h40, 16'hAAAA);
    set_cmd(1'b1, 1'b0, 1'b0, 4'd5, 14'h0A, 16'h0);
    hc = 0;
    cc = 0;
    for (int i = 0; i < 100 && cc < 2; i++) begin
      @(negedge clk);
      if (h_gnt === 1'b1) begin
        hc++;
        if (hc == 3) h_req = 1'b0;
      end
      if (c_gnt === 1'b1) begin
        cc++;
        if (cc == 2) c_req = 1'b0;
      end
    end
    chk("contention_c_grants", 64'(cc), 64'd2);
    wait_idle();
`ifdef MEM_ARB_PERF_EN
    chk("perf_h_grants", 64'(perf_h_grants), 64'd3);
    chk("perf_c_grants", 64'(perf_c_grants), 64'd2);
    chk("perf_c_stall", 64'(perf_c_stall), 64'd9);
`else
    chk("perf_tied_off", 64'({perf_h_grants, perf_c_grants, perf_c_stall}), 64'd0);
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
